// File: rtl/interface_sensor_ultrassom_if.sv
`default_nettype none
// ============================================================================
// Module   : interface_sensor_ultrassom_if
// Brief    : Request/result bundle between a controller and the ultrasonic
//            sensor front end (request, raw echo, trigger, result strobe).
// Revision : 1.0 - initial release
// ============================================================================
interface interface_sensor_ultrassom_if #(
    parameter int N = 9
);
    logic         medir;
    logic         echo;
    logic         trigger;
    logic [N-1:0] medida;
    logic         pronto;
    logic         erro;
    logic         ocupado;

    modport master (
        output medir,
        output echo,
        input  trigger,
        input  medida,
        input  pronto,
        input  erro,
        input  ocupado
    );

    modport slave (
        input  medir,
        input  echo,
        output trigger,
        output medida,
        output pronto,
        output erro,
        output ocupado
    );
endinterface
`default_nettype wire

// File: rtl/interface_sensor_ultrassom.sv
`default_nettype none
// ============================================================================
// Module   : interface_sensor_ultrassom
// Brief    : HC-SR04-style sensor driver: trigger pulse, echo timing, rounded
//            centimetre result with a one-cycle pronto strobe (0 = error).
// Revision : 1.0 - initial release
// ============================================================================
module interface_sensor_ultrassom #(
    parameter int N              = 9,
    parameter int CICLOS_TRIGGER = 500,
    parameter int CICLOS_CM      = 2941,
    parameter int CICLOS_TIMEOUT = 1_600_000
) (
    input  wire logic                    clock,
    input  wire logic                    reset,
    interface_sensor_ultrassom_if.slave  sensor
);

    localparam int c_W_TRIG = (CICLOS_TRIGGER > 1) ? $clog2(CICLOS_TRIGGER) : 1;
    localparam int c_W_SUB  = (CICLOS_CM > 1)      ? $clog2(CICLOS_CM)      : 1;
    localparam int c_W_TMO  = (CICLOS_TIMEOUT > 1) ? $clog2(CICLOS_TIMEOUT) : 1;

    localparam logic [c_W_TRIG-1:0] c_TRIG_MAX = c_W_TRIG'(CICLOS_TRIGGER - 1);
    localparam logic [c_W_SUB-1:0]  c_SUB_MAX  = c_W_SUB'(CICLOS_CM - 1);
    localparam logic [c_W_SUB-1:0]  c_SUB_HALF = c_W_SUB'(CICLOS_CM / 2);
    localparam logic [c_W_TMO-1:0]  c_TMO_MAX  = c_W_TMO'(CICLOS_TIMEOUT - 1);
    localparam logic [N-1:0]        c_CM_MAX   = '1;
    localparam logic [N-1:0]        c_CM_ONE   = N'(1);

    typedef enum logic [2:0] {
        ST_INICIAL       = 3'd0,
        ST_ENVIA_TRIGGER = 3'd1,
        ST_ESPERA_ECHO   = 3'd2,
        ST_MEDINDO       = 3'd3,
        ST_FIM_OK        = 3'd4,
        ST_FIM_ERRO      = 3'd5
    } state_t;

    state_t              r_state,   w_state_next;
    logic                r_echo_meta, r_echo_s, r_echo_d;
    logic [c_W_TRIG-1:0] r_trig_cnt, w_trig_cnt_next;
    logic [c_W_SUB-1:0]  r_sub,     w_sub_next;
    logic [N-1:0]        r_cm,      w_cm_next;
    logic [c_W_TMO-1:0]  r_tmo,     w_tmo_next;
    logic                r_trigger, w_trigger_next;
    logic [N-1:0]        r_medida,  w_medida_next;
    logic                r_pronto,  w_pronto_next;
    logic                r_erro,    w_erro_next;
    logic                r_ocupado, w_ocupado_next;

    logic                w_rise;
    logic                w_tmo_fim;
    logic                w_sub_wrap;
    logic [c_W_SUB-1:0]  w_sub_step;
    logic [N-1:0]        w_cm_step;
    logic [N-1:0]        w_cm_round;
    logic [N-1:0]        w_cm_final;

    assign w_rise     = r_echo_s & ~r_echo_d;
    assign w_tmo_fim  = (r_tmo == c_TMO_MAX);

    // One echo cycle: sub-counter wraps every CICLOS_CM cycles, bumping the saturating cm count.
    assign w_sub_wrap = (r_sub == c_SUB_MAX);
    assign w_sub_step = w_sub_wrap ? '0 : r_sub + c_W_SUB'(1);
    assign w_cm_step  = (w_sub_wrap && (r_cm != c_CM_MAX)) ? r_cm + c_CM_ONE : r_cm;

    // Round half up, then keep 0 reserved for errors.
    assign w_cm_round = ((r_sub >= c_SUB_HALF) && (r_cm != c_CM_MAX)) ? r_cm + c_CM_ONE : r_cm;
    assign w_cm_final = (w_cm_round == '0) ? c_CM_ONE : w_cm_round;

    always_comb begin
        w_state_next    = r_state;
        w_trig_cnt_next = r_trig_cnt;
        w_sub_next      = r_sub;
        w_cm_next       = r_cm;
        w_tmo_next      = r_tmo;
        w_trigger_next  = 1'b0;
        w_medida_next   = r_medida;
        w_pronto_next   = 1'b0;
        w_erro_next     = r_erro;

        case (r_state)
            ST_INICIAL: begin
                if (sensor.medir) begin
                    w_state_next    = ST_ENVIA_TRIGGER;
                    w_trigger_next  = 1'b1;
                    w_trig_cnt_next = '0;
                    w_sub_next      = '0;
                    w_cm_next       = '0;
                    w_tmo_next      = '0;
                end
            end
            ST_ENVIA_TRIGGER: begin
                if (r_trig_cnt == c_TRIG_MAX) begin
                    w_state_next = ST_ESPERA_ECHO;
                end else begin
                    w_trig_cnt_next = r_trig_cnt + c_W_TRIG'(1);
                    w_trigger_next  = 1'b1;
                end
            end
            ST_ESPERA_ECHO: begin
                if (w_tmo_fim) begin
                    w_state_next = ST_FIM_ERRO;
                end else begin
                    w_tmo_next = r_tmo + c_W_TMO'(1);
                    if (w_rise) begin
                        w_state_next = ST_MEDINDO;
                        w_sub_next   = w_sub_step;
                        w_cm_next    = w_cm_step;
                    end
                end
            end
            ST_MEDINDO: begin
                if (w_tmo_fim) begin
                    w_state_next = ST_FIM_ERRO;
                end else if (r_echo_s) begin
                    w_tmo_next = r_tmo + c_W_TMO'(1);
                    w_sub_next = w_sub_step;
                    w_cm_next  = w_cm_step;
                end else begin
                    w_state_next = ST_FIM_OK;
                end
            end
            ST_FIM_OK: begin
                w_medida_next = w_cm_final;
                w_erro_next   = 1'b0;
                w_pronto_next = 1'b1;
                w_state_next  = ST_INICIAL;
            end
            ST_FIM_ERRO: begin
                w_medida_next = '0;
                w_erro_next   = 1'b1;
                w_pronto_next = 1'b1;
                w_state_next  = ST_INICIAL;
            end
            default: begin
                w_state_next = ST_INICIAL;
            end
        endcase

        w_ocupado_next = (w_state_next != ST_INICIAL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_INICIAL;
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
            r_echo_d    <= 1'b0;
            r_trig_cnt  <= '0;
            r_sub       <= '0;
            r_cm        <= '0;
            r_tmo       <= '0;
            r_trigger   <= 1'b0;
            r_medida    <= '0;
            r_pronto    <= 1'b0;
            r_erro      <= 1'b0;
            r_ocupado   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_echo_meta <= sensor.echo;
            r_echo_s    <= r_echo_meta;
            r_echo_d    <= r_echo_s;
            r_trig_cnt  <= w_trig_cnt_next;
            r_sub       <= w_sub_next;
            r_cm        <= w_cm_next;
            r_tmo       <= w_tmo_next;
            r_trigger   <= w_trigger_next;
            r_medida    <= w_medida_next;
            r_pronto    <= w_pronto_next;
            r_erro      <= w_erro_next;
            r_ocupado   <= w_ocupado_next;
        end
    end

    assign sensor.trigger = r_trigger;
    assign sensor.medida  = r_medida;
    assign sensor.pronto  = r_pronto;
    assign sensor.erro    = r_erro;
    assign sensor.ocupado = r_ocupado;

endmodule
`default_nettype wire

// File: tb/tb_interface_sensor_ultrassom.sv
`default_nettype none
// ============================================================================
// Module   : tb_interface_sensor_ultrassom
// Brief    : Randomised and directed bench for the ultrasonic sensor driver,
//            scaled-down timing parameters, arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interface_sensor_ultrassom;

    localparam int N   = 6;
    localparam int CT  = 5;
    localparam int CM  = 21;
    localparam int TMO = 1600;
    localparam int BOUND = 5000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    interface_sensor_ultrassom_if #(.N(N)) sensor ();

    interface_sensor_ultrassom #(
        .N              (N),
        .CICLOS_TRIGGER (CT),
        .CICLOS_CM      (CM),
        .CICLOS_TIMEOUT (TMO)
    ) u_dut (
        .clock  (clock),
        .reset  (reset),
        .sensor (sensor.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Whole centimetres from echo length: round half up, saturate, never 0.
    function automatic int exp_cm(input int len);
        int v;
        v = len / CM;
        if ((len % CM) >= (CM / 2)) v = v + 1;
        if (v > (1 << N) - 1) v = (1 << N) - 1;
        if (v < 1) v = 1;
        return v;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (sensor.ocupado && k < BOUND) begin
            @(posedge clock); #1; k++;
        end
        if (k >= BOUND) chk_val("idle_timeout", 0, 1);
    endtask

    task automatic start_meas();
        wait_idle();
        @(posedge clock); #1 sensor.medir = 1'b1;
        @(posedge clock); #1 sensor.medir = 1'b0;
        chk_val("trig_start", int'(sensor.trigger), 1);
        chk_val("ocupado_busy", int'(sensor.ocupado), 1);
    endtask

    task automatic trig_width();
        int n = 0;
        while (sensor.trigger && n < BOUND) begin
            @(posedge clock); #1; n++;
        end
        chk_val("trig_width", n, CT);
    endtask

    task automatic echo_drive(input int dly, input int len, input bit pulse_busy);
        if (pulse_busy) begin
            @(posedge clock); #1 sensor.medir = 1'b1;
            @(posedge clock); #1 sensor.medir = 1'b0;
        end
        if (len > 0) begin
            repeat (dly) @(posedge clock);
            #1 sensor.echo = 1'b1;
            repeat (len) @(posedge clock);
            #1 sensor.echo = 1'b0;
        end
    endtask

    task automatic wait_pronto(output int k);
        k = 0;
        while (!sensor.pronto && k < BOUND) begin
            @(posedge clock); #1; k++;
        end
        if (k >= BOUND) chk_val("pronto_timeout", 0, 1);
    endtask

    // One measurement; len=0 means no echo. Starts right after the trigger edge when start=0.
    task automatic meas(input int dly, input int len, input bit exp_err, input int exp_med,
                        input bit chk_lat, input bit pulse_busy, input bit start);
        int k;
        if (start) start_meas();
        trig_width();
        fork
            echo_drive(dly, len, pulse_busy);
            begin
                wait_pronto(k);
                chk_val("erro", int'(sensor.erro), int'(exp_err));
                chk_val("medida", int'(sensor.medida), exp_med);
                chk_val("ocupado_at_pronto", int'(sensor.ocupado), 0);
                if (chk_lat) chk_val("tmo_latency", k, TMO + 1);
                @(posedge clock); #1;
                chk_val("pronto_one_cycle", int'(sensor.pronto), 0);
                chk_val("trigger_after_pronto", int'(sensor.trigger), int'(sensor.medir));
            end
        join
    endtask

    initial begin
        int cnt;
        int len;
        int dly;

        sensor.medir = 1'b0;
        sensor.echo  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_val("rst_trigger", int'(sensor.trigger), 0);
        chk_val("rst_medida", int'(sensor.medida), 0);
        chk_val("rst_pronto", int'(sensor.pronto), 0);
        chk_val("rst_erro", int'(sensor.erro), 0);
        chk_val("rst_ocupado", int'(sensor.ocupado), 0);
        reset = 1'b0;

        // Exact multiple, rounding threshold on both sides, clamp, saturation.
        meas(3, 10 * CM,          1'b0, 10, 1'b0, 1'b0, 1'b1);
        meas(0, 10 * CM + CM/2-1, 1'b0, 10, 1'b0, 1'b0, 1'b1);
        meas(0, 10 * CM + CM/2,   1'b0, 11, 1'b0, 1'b1, 1'b1);
        meas(2, 5,                1'b0, 1,  1'b0, 1'b0, 1'b1);
        meas(0, 70 * CM,          1'b0, 63, 1'b0, 1'b0, 1'b1);

        // No echo, echo too long, echo already high before the trigger.
        meas(0, 0,       1'b1, 0, 1'b1, 1'b0, 1'b1);
        meas(1, 2000,    1'b1, 0, 1'b0, 1'b0, 1'b1);
        meas(1, 4 * CM,  1'b0, 4, 1'b0, 1'b0, 1'b1);
        sensor.echo = 1'b1;
        meas(0, TMO + 100, 1'b1, 0, 1'b1, 1'b0, 1'b1);
        sensor.echo = 1'b0;
        chk_val("erro_held", int'(sensor.erro), 1);

        for (int i = 0; i < 8; i++) begin
            len = $urandom_range(1, 1400);
            dly = $urandom_range(0, 20);
            meas(dly, len, 1'b0, exp_cm(len), 1'b0, i[0], 1'b1);
        end

        // Reset in the middle of an echo.
        start_meas();
        trig_width();
        repeat (3) @(posedge clock);
        #1 sensor.echo = 1'b1;
        repeat (50) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk_val("midrst_trigger", int'(sensor.trigger), 0);
        chk_val("midrst_ocupado", int'(sensor.ocupado), 0);
        chk_val("midrst_medida", int'(sensor.medida), 0);
        chk_val("midrst_pronto", int'(sensor.pronto), 0);
        reset = 1'b0;
        sensor.echo = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(posedge clock); #1;
            if (sensor.pronto || sensor.ocupado) cnt++;
        end
        chk_val("midrst_quiet", cnt, 0);
        meas(2, 7 * CM + 3, 1'b0, 7, 1'b0, 1'b0, 1'b1);

        // medir held high: back-to-back measurements with one INICIAL cycle between.
        wait_idle();
        @(posedge clock); #1 sensor.medir = 1'b1;
        @(posedge clock); #1;
        chk_val("held_trig_start", int'(sensor.trigger), 1);
        meas(1, 12 * CM, 1'b0, 12, 1'b0, 1'b0, 1'b0);
        sensor.medir = 1'b0;
        meas(1, 3 * CM + 15, 1'b0, 4, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        chk_val("held_idle_after", int'(sensor.ocupado), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
